// File: rtl/display_scan.sv
// rtl/display_scan.sv - multi-digit BCD display scanner with frame-aligned double buffering
module display_scan #(
    parameter int NUM_DIGITS      = 4,
    parameter int TICKS_PER_DIGIT = 20000
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    LOAD,
    input  logic [4*NUM_DIGITS-1:0] VALUE,
    input  logic                    BLANK_LZ,
    output logic [3:0]              DIGIT,
    output logic [NUM_DIGITS-1:0]   DIGIT_EN,
    output logic                    FRAME_DONE,
    output logic                    LOAD_ACK
);

    localparam int TW = (TICKS_PER_DIGIT > 2) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    logic [TW-1:0]         tcnt;
    logic [IW-1:0]         idx;
    logic [VW-1:0]         shadow;
    logic [VW-1:0]         active;
    logic                  pending;

    logic                  tc;
    logic                  fb;
    logic [VW-1:0]         upper;
    logic                  blank;
    logic [NUM_DIGITS-1:0] one_hot;

    // upper holds the current digit and every digit above it; all-zero means a leading zero
    always_comb begin
        tc      = (tcnt == TW'(TICKS_PER_DIGIT - 1));
        fb      = tc && (idx == IW'(NUM_DIGITS - 1));
        upper   = active >> {idx, 2'b00};
        blank   = BLANK_LZ && (idx != '0) && (upper == '0);
        one_hot = NUM_DIGITS'(1) << idx;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tcnt       <= '0;
            idx        <= '0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            DIGIT      <= 4'h0;
            DIGIT_EN   <= '1;
            FRAME_DONE <= 1'b0;
            LOAD_ACK   <= 1'b0;
        end else begin
            tcnt <= tc ? '0 : tcnt + TW'(1);
            if (tc) begin
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
            end

            if (LOAD) begin
                shadow <= VALUE;
            end

            // A load landing on the boundary bypasses the shadow so it is not acked twice
            if (fb) begin
                if (LOAD) begin
                    active <= VALUE;
                end else if (pending) begin
                    active <= shadow;
                end
                pending  <= 1'b0;
                LOAD_ACK <= LOAD || pending;
            end else begin
                if (LOAD) begin
                    pending <= 1'b1;
                end
                LOAD_ACK <= 1'b0;
            end

            FRAME_DONE <= fb;
            DIGIT      <= upper[3:0];
            DIGIT_EN   <= blank ? '1 : ~one_hot;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - randomized and directed bench for display_scan against a frame-arithmetic model
module tb_display_scan;

    localparam int N  = 4;
    localparam int T  = 4;
    localparam int FR = N * T;

    logic        CLK;
    logic        RESET_N;
    logic        LOAD;
    logic [15:0] VALUE;
    logic        BLANK_LZ;
    logic [3:0]  DIGIT;
    logic [3:0]  DIGIT_EN;
    logic        FRAME_DONE;
    logic        LOAD_ACK;

    int checks   = 0;
    int failures = 0;

    int          m_cycle;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    logic        m_pending;
    logic [3:0]  exp_digit;
    logic [3:0]  exp_en;
    logic        exp_fd;
    logic        exp_ack;

    display_scan #(.NUM_DIGITS(N), .TICKS_PER_DIGIT(T)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .LOAD(LOAD), .VALUE(VALUE), .BLANK_LZ(BLANK_LZ),
        .DIGIT(DIGIT), .DIGIT_EN(DIGIT_EN), .FRAME_DONE(FRAME_DONE), .LOAD_ACK(LOAD_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_cycle   = 0;
        m_active  = 16'h0;
        m_shadow  = 16'h0;
        m_pending = 1'b0;
    endtask

    // Scan position follows from the edge count since reset release alone
    task automatic model_edge(input logic ld, input logic [15:0] val, input logic blz);
        int   pos;
        int   ci;
        logic fbnd;
        pos       = m_cycle % FR;
        ci        = pos / T;
        fbnd      = (pos == FR - 1);
        exp_digit = 4'((m_active >> (4 * ci)) & 16'hF);
        exp_en    = (blz && ci > 0 && (m_active >> (4 * ci)) == 16'h0) ? 4'hF : ~(4'(4'd1 << ci));
        exp_fd    = fbnd;
        exp_ack   = fbnd && (ld || m_pending);
        if (fbnd) begin
            if (ld) m_active = val;
            else if (m_pending) m_active = m_shadow;
            m_pending = 1'b0;
        end else if (ld) begin
            m_shadow  = val;
            m_pending = 1'b1;
        end
        m_cycle++;
    endtask

    task automatic step(input logic ld, input logic [15:0] val);
        @(negedge CLK);
        LOAD  = ld;
        VALUE = val;
        model_edge(ld, val, BLANK_LZ);
        @(posedge CLK);
        #1;
        LOAD = 1'b0;
    endtask

    task automatic align(input int target);
        for (int i = 0; i < FR && (m_cycle % FR) != target; i++) step(1'b0, 16'h0);
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; LOAD = 1'b0; VALUE = 16'h0; BLANK_LZ = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK} !== {4'h0, 4'hF, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got d=%h en=%b fd=%b ack=%b want d=0 en=1111 fd=0 ack=0",
                     DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK);
        end
        RESET_N = 1'b1;
        model_reset();
    endtask

    task automatic test_idle_scan();
        int fd_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 16'h0);
            checks++;
            if ({DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK} !== {exp_digit, exp_en, exp_fd, exp_ack}) begin
                failures++;
                $display("FAIL idle_scan cyc=%0d got d=%h en=%b fd=%b ack=%b want d=%h en=%b fd=%b ack=%b",
                         i, DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK, exp_digit, exp_en, exp_fd, exp_ack);
            end
            if (i == 0) begin
                checks++;
                if (DIGIT_EN !== 4'b1110 || DIGIT !== 4'h0) begin
                    failures++;
                    $display("FAIL first_edge got d=%h en=%b want d=0 en=1110", DIGIT, DIGIT_EN);
                end
            end
            fd_cnt += int'(FRAME_DONE);
        end
        checks++;
        if (fd_cnt != 2) begin
            failures++;
            $display("FAIL idle_frame_count got %0d want 2", fd_cnt);
        end
    endtask

    task automatic test_load_commit();
        int ack_cnt = 0;
        int after   = -1;
        align(6);
        step(1'b1, 16'h1234);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 16'h0);
            checks++;
            if ({DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK} !== {exp_digit, exp_en, exp_fd, exp_ack}) begin
                failures++;
                $display("FAIL load_commit cyc=%0d got d=%h en=%b fd=%b ack=%b want d=%h en=%b fd=%b ack=%b",
                         i, DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK, exp_digit, exp_en, exp_fd, exp_ack);
            end
            if (after >= 0 && after < FR && after % T == 0) begin
                logic [15:0] ref_val;
                ref_val = 16'h1234;
                checks++;
                if (DIGIT !== ref_val[4 * (after / T) +: 4]) begin
                    failures++;
                    $display("FAIL commit_digit idx=%0d got %h want %h", after / T, DIGIT,
                             ref_val[4 * (after / T) +: 4]);
                end
            end
            if (after >= 0) after++;
            if (LOAD_ACK) begin
                ack_cnt++;
                checks++;
                if (FRAME_DONE !== 1'b1) begin
                    failures++;
                    $display("FAIL ack_with_frame_done got fd=%b want 1", FRAME_DONE);
                end
                after = 0;
            end
        end
        checks++;
        if (ack_cnt != 1) begin
            failures++;
            $display("FAIL load_commit_acks got %0d want 1", ack_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int   ack_cnt = 0;
        logic chk_next = 1'b0;
        align(2);
        step(1'b1, 16'h1111);
        step(1'b0, 16'h0);
        step(1'b1, 16'h0008);
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 16'h0);
            checks++;
            if ({DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK} !== {exp_digit, exp_en, exp_fd, exp_ack}) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got d=%h en=%b fd=%b ack=%b want d=%h en=%b fd=%b ack=%b",
                         i, DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK, exp_digit, exp_en, exp_fd, exp_ack);
            end
            if (chk_next) begin
                checks++;
                if (DIGIT !== 4'h8 || DIGIT_EN !== 4'b1110) begin
                    failures++;
                    $display("FAIL back_to_back_digit0 got d=%h en=%b want d=8 en=1110", DIGIT, DIGIT_EN);
                end
                chk_next = 1'b0;
            end
            if (LOAD_ACK) begin
                ack_cnt++;
                chk_next = 1'b1;
            end
        end
        checks++;
        if (ack_cnt != 1) begin
            failures++;
            $display("FAIL back_to_back_acks got %0d want 1", ack_cnt);
        end
    endtask

    task automatic test_load_on_fb();
        int ack_cnt = 0;
        align(FR - 1);
        step(1'b1, 16'h5678);
        checks++;
        if (LOAD_ACK !== 1'b1 || FRAME_DONE !== 1'b1) begin
            failures++;
            $display("FAIL fb_load_ack got ack=%b fd=%b want ack=1 fd=1", LOAD_ACK, FRAME_DONE);
        end
        step(1'b0, 16'h0);
        checks++;
        if (DIGIT !== 4'h8 || DIGIT_EN !== 4'b1110) begin
            failures++;
            $display("FAIL fb_load_digit0 got d=%h en=%b want d=8 en=1110", DIGIT, DIGIT_EN);
        end
        for (int i = 0; i < FR + 2; i++) begin
            step(1'b0, 16'h0);
            checks++;
            if ({DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK} !== {exp_digit, exp_en, exp_fd, exp_ack}) begin
                failures++;
                $display("FAIL load_on_fb cyc=%0d got d=%h en=%b fd=%b ack=%b want d=%h en=%b fd=%b ack=%b",
                         i, DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK, exp_digit, exp_en, exp_fd, exp_ack);
            end
            ack_cnt += int'(LOAD_ACK);
        end
        checks++;
        if (ack_cnt != 0) begin
            failures++;
            $display("FAIL fb_load_second_ack got %0d want 0", ack_cnt);
        end
    endtask

    task automatic test_blanking();
        logic [15:0] vals [2];
        int          want_dark [2];
        vals[0] = 16'h0040; want_dark[0] = 2 * T;
        vals[1] = 16'h0000; want_dark[1] = 3 * T;
        BLANK_LZ = 1'b1;
        for (int v = 0; v < 2; v++) begin
            int dark = 0;
            int seen = 0;
            int lit0 = 0;
            align(3);
            step(1'b1, vals[v]);
            for (int i = 0; i < 40; i++) begin
                step(1'b0, 16'h0);
                checks++;
                if ({DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK} !== {exp_digit, exp_en, exp_fd, exp_ack}) begin
                    failures++;
                    $display("FAIL blanking v=%h cyc=%0d got d=%h en=%b fd=%b ack=%b want d=%h en=%b fd=%b ack=%b",
                             vals[v], i, DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK, exp_digit, exp_en, exp_fd, exp_ack);
                end
                if (seen > 0 && seen <= FR) begin
                    dark += int'(DIGIT_EN == 4'hF);
                    lit0 += int'(DIGIT_EN == 4'b1110);
                    seen++;
                end
                if (LOAD_ACK) seen = 1;
            end
            checks++;
            if (dark != want_dark[v] || lit0 != T) begin
                failures++;
                $display("FAIL blank_counts v=%h got dark=%0d lit0=%0d want dark=%0d lit0=%0d",
                         vals[v], dark, lit0, want_dark[v], T);
            end
        end
        BLANK_LZ = 1'b0;
    endtask

    task automatic test_reset_mid();
        int ack_cnt = 0;
        align(1);
        step(1'b1, 16'h9999);
        align(2 * T + 1);
        @(negedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK} !== {4'h0, 4'hF, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got d=%h en=%b fd=%b ack=%b want d=0 en=1111 fd=0 ack=0",
                     DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK);
        end
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * FR + 2; i++) begin
            step(1'b0, 16'h0);
            checks++;
            if ({DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK} !== {exp_digit, exp_en, exp_fd, exp_ack}
                || DIGIT !== 4'h0) begin
                failures++;
                $display("FAIL reset_mid cyc=%0d got d=%h en=%b fd=%b ack=%b want d=%h en=%b fd=%b ack=%b",
                         i, DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK, exp_digit, exp_en, exp_fd, exp_ack);
            end
            ack_cnt += int'(LOAD_ACK);
        end
        checks++;
        if (ack_cnt != 0) begin
            failures++;
            $display("FAIL reset_mid_acks got %0d want 0", ack_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            logic        ld;
            logic [15:0] v;
            ld = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) begin
                v = 16'($urandom);
            end else begin
                for (int d = 0; d < N; d++) v[4 * d +: 4] = 4'($urandom_range(0, 9));
                if ($urandom_range(0, 1) == 1) v[15:8] = 8'h00;
            end
            if ($urandom_range(0, 99) == 0) BLANK_LZ = ~BLANK_LZ;
            step(ld, v);
            checks++;
            if ({DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK} !== {exp_digit, exp_en, exp_fd, exp_ack}) begin
                failures++;
                $display("FAIL random cyc=%0d got d=%h en=%b fd=%b ack=%b want d=%h en=%b fd=%b ack=%b",
                         i, DIGIT, DIGIT_EN, FRAME_DONE, LOAD_ACK, exp_digit, exp_en, exp_fd, exp_ack);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_scan();
        test_load_commit();
        test_back_to_back();
        test_load_on_fb();
        test_blanking();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexing scanner that feeds the `display` segment decoder. It holds a multi-digit BCD value and cycles through the digits at a fixed refresh rate. On each cycle it presents one nibble on `DIGIT` to the decoder and drives the matching active-low digit enable. New values are double-buffered and only committed at a frame boundary, so the display never tears.

## Interface
- `NUM_DIGITS`, 4: number of display digits; legal range 2..8.
- `TICKS_PER_DIGIT`, 20000: CLK cycles each digit stays lit (1 ms at 20 MHz); legal minimum 2.
- `CLK`  in  1  system clock, 20 MHz.
- `RESET_N`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `LOAD`  in  1  one-cycle strobe; capture `VALUE` into the shadow register.
- `VALUE`  in  4*NUM_DIGITS  BCD value; nibble 0 (`[3:0]`) is the least significant digit.
- `BLANK_LZ`  in  1  1 = suppress leading zeros.
- `DIGIT`  out  4  nibble for the `display` decoder's `DIGIT` input.
- `DIGIT_EN`  out  NUM_DIGITS  one-hot-low digit enable; bit i lights digit i.
- `FRAME_DONE`  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.
- `LOAD_ACK`  out  1  one-cycle pulse when a pending value is committed to the active register.

## Operation
- **Tick counter `tcnt`:** counts 0..TICKS_PER_DIGIT-1 and wraps. Its terminal count (TC) is `tcnt == TICKS_PER_DIGIT-1`.
- **Digit index `idx`:** 0..NUM_DIGITS-1. It advances on TC and wraps from NUM_DIGITS-1 to 0. That wrap is the frame boundary (FB).
- **Shadow register `shadow`:** loaded from `VALUE` on `LOAD`, which also sets `pending`. If `LOAD` arrives while `pending` is already set, the shadow is overwritten: last value wins, and only one ACK follows.
- **Commit at FB:**
  - If `pending`, copy `shadow` into `active`, clear `pending`, and pulse `LOAD_ACK`.
  - If `LOAD` and FB fall on the same cycle, `VALUE` goes straight to `active` and `LOAD_ACK` pulses; `pending` ends cleared.
- **Digit output:** `DIGIT` = `active[4*idx +: 4]`. Nibbles above 9 pass through unchanged; the decoder shows its invalid pattern for them.
- **Leading-zero blanking:** when `BLANK_LZ` is 1, digit i (i > 0) is blanked if it and every higher digit in `active` are 0. Digit 0 is never blanked.
  - A blanked digit drives `DIGIT_EN` all ones.
  - `DIGIT` still carries the nibble.
- **Enable output:** `DIGIT_EN` = ~(1 << idx) when the digit is not blanked.
- **`FRAME_DONE`:** pulses on every FB, independent of `LOAD`.
- **Reset** (asynchronous, any time, including mid-frame or with a pending load):
  - `tcnt`, `idx`, `shadow`, `active` and `pending` are cleared.
  - `DIGIT` = 0, `DIGIT_EN` = all ones, `FRAME_DONE` = 0, `LOAD_ACK` = 0.
  - The pending load is discarded and no ACK is issued.

## Timing
- All outputs are registered. `DIGIT` and `DIGIT_EN` reflect `idx` and `active` with one cycle of latency.
  - First edge after reset release: `DIGIT` = 0, `DIGIT_EN` = ~1 (all ones except bit 0).
- `FRAME_DONE` and `LOAD_ACK` are asserted in the cycle after the FB edge, for exactly one cycle.
- **Dwell:** each digit is held for exactly TICKS_PER_DIGIT cycles. A frame is NUM_DIGITS*TICKS_PER_DIGIT cycles.
- **Load-to-display latency:** from `LOAD` to the first display of the new value, at most one frame plus 1 cycle.
- Blanking is evaluated on `active`. It changes only at FB or when `BLANK_LZ` toggles, and takes effect on the next edge.
- `BLANK_LZ` is sampled every cycle; it is static in normal use.

## Test plan
Bench settings: NUM_DIGITS = 4, TICKS_PER_DIGIT = 4.

1. **Reset and idle scan.**
   - Stimulus: assert reset, release, no `LOAD`.
   - Response: `DIGIT_EN` steps 1110 → 1101 → 1011 → 0111, each held 4 cycles. `DIGIT` = 0 throughout. `FRAME_DONE` pulses every 16 cycles.
2. **Load and commit.**
   - Stimulus: mid-frame `LOAD` of `VALUE` = 16'h1234.
   - Response: the old value stays until FB. `LOAD_ACK` pulses once with `FRAME_DONE`. The next frame shows `DIGIT` 4, 3, 2, 1 on idx 0..3. The decoder input 1 yields `SEGMENT` 16'b0110000000100000.
3. **Back-to-back loads.**
   - Stimulus: `LOAD` 16'h1111, then `LOAD` 16'h0008 two cycles later, both before FB.
   - Response: a single `LOAD_ACK`. The frame shows 8, 0, 0, 0.
4. **Load on frame boundary.**
   - Stimulus: `LOAD` 16'h5678 in the FB cycle.
   - Response: `LOAD_ACK` pulses in that boundary's pulse cycle. Digit 0 shows 8 immediately. No second ACK at the next FB.
5. **Leading-zero blanking.**
   - Stimulus: `active` = 16'h0040 with `BLANK_LZ` = 1.
   - Response: digits 3 and 2 give `DIGIT_EN` = 1111. Digits 1 and 0 give 1101 and 1110. With 16'h0000, only digit 0 is lit.
6. **Reset mid-operation.**
   - Stimulus: pending `LOAD` 16'h9999, then `RESET_N` low on idx 2.
   - Response: outputs go to reset values immediately (asynchronously). No `LOAD_ACK`. After release, the display shows 0000.
